// File: rtl/multicycle_mem_ctrl_if.sv
// Handshake and data bus between the multi-cycle control unit and the
// unified instruction/data memory controller.
interface multicycle_mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              mem_read;
   logic              mem_write;
   logic              ir_write;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              mem_ready;
   logic              busy;
   logic [31:0]       ir_out;
   logic [31:0]       mdr_out;
   logic              access_err;

   modport master (
      output mem_read, mem_write, ir_write, addr, wdata,
      input  mem_ready, busy, ir_out, mdr_out, access_err
   );

   modport slave (
      input  mem_read, mem_write, ir_write, addr, wdata,
      output mem_ready, busy, ir_out, mdr_out, access_err
   );
endinterface

// File: rtl/multicycle_mem_ctrl.sv
// Unified word-wide memory controller with fixed access latency; owns the
// instruction register and memory data register of the multi-cycle core.
module multicycle_mem_ctrl #(
   parameter int MEM_DEPTH = 16384,
   parameter int LATENCY   = 2,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_mem_ctrl_if.slave bus
);
   localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              is_write_q;
   logic              to_ir_q;

   logic [31:0]       mem [MEM_DEPTH];

   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  idx;
   logic              in_range;
   logic              misaligned;
   logic [31:0]       rdata;

   assign word_idx   = addr_q >> 2;
   assign idx        = word_idx[IDX_W-1:0];
   assign in_range   = word_idx < ADDR_W'(MEM_DEPTH);
   assign misaligned = addr_q[1:0] != 2'b00;
   // Out-of-range reads return zero rather than aliasing into the array.
   assign rdata      = in_range ? mem[idx] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         is_write_q     <= 1'b0;
         to_ir_q        <= 1'b0;
         bus.mem_ready  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.ir_out     <= '0;
         bus.mdr_out    <= '0;
         bus.access_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.mem_ready  <= 1'b0;
               bus.access_err <= 1'b0;
               if (bus.mem_read || bus.mem_write) begin
                  addr_q     <= bus.addr;
                  wdata_q    <= bus.wdata;
                  is_write_q <= bus.mem_write;
                  to_ir_q    <= bus.ir_write;
                  cnt        <= CNT_INIT;
                  bus.busy   <= 1'b1;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state          <= DONE;
                  bus.mem_ready  <= 1'b1;
                  bus.access_err <= misaligned;
                  if (!misaligned) begin
                     if (is_write_q) begin
                        if (in_range) mem[idx] <= wdata_q;
                     end else if (to_ir_q) begin
                        bus.ir_out <= rdata;
                     end else begin
                        bus.mdr_out <= rdata;
                     end
                  end
               end
            end
            DONE: begin
               bus.mem_ready  <= 1'b0;
               bus.busy       <= 1'b0;
               bus.access_err <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_mem_ctrl.sv
// Directed bench for the memory controller: a LATENCY=2 instance for the
// functional cases and LATENCY=1/4 instances for the latency sweep.
module tb_multicycle_mem_ctrl;
   localparam int DEPTH = 16384;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0, wr = 1'b0, irw = 1'b0, sweep_en = 1'b0;
   logic [31:0] a = '0, d = '0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   multicycle_mem_ctrl_if #(.ADDR_W(32)) mif0 ();
   multicycle_mem_ctrl_if #(.ADDR_W(32)) mif1 ();
   multicycle_mem_ctrl_if #(.ADDR_W(32)) mif4 ();

   assign mif0.mem_read  = rd & ~sweep_en;
   assign mif0.mem_write = wr & ~sweep_en;
   assign mif0.ir_write  = irw;
   assign mif0.addr      = a;
   assign mif0.wdata     = d;
   assign mif1.mem_read  = rd & sweep_en;
   assign mif1.mem_write = wr & sweep_en;
   assign mif1.ir_write  = irw;
   assign mif1.addr      = a;
   assign mif1.wdata     = d;
   assign mif4.mem_read  = rd & sweep_en;
   assign mif4.mem_write = wr & sweep_en;
   assign mif4.ir_write  = irw;
   assign mif4.addr      = a;
   assign mif4.wdata     = d;

   multicycle_mem_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(2), .ADDR_W(32)) dut0 (
      .clk(clk), .reset(reset), .bus(mif0.slave));
   multicycle_mem_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(1), .ADDR_W(32)) dut1 (
      .clk(clk), .reset(reset), .bus(mif1.slave));
   multicycle_mem_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(4), .ADDR_W(32)) dut4 (
      .clk(clk), .reset(reset), .bus(mif4.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd = 1'b0; wr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Holds the strobes until mem_ready, as the control unit does.
   task automatic req(input string tag, input logic r, input logic w, input logic ir,
                      input logic [31:0] adr, input logic [31:0] dat, input logic exp_err);
      int   n;
      logic busy_ok;
      logic err;
      n = 0; busy_ok = 1'b1; err = 1'b0;
      @(negedge clk);
      rd = r; wr = w; irw = ir; a = adr; d = dat;
      @(negedge clk);
      for (int k = 1; k <= 20 && n == 0; k++) begin
         busy_ok &= mif0.busy;
         if (mif0.mem_ready) begin
            n = k;
            err = mif0.access_err;
         end else begin
            @(negedge clk);
         end
      end
      rd = 1'b0; wr = 1'b0;
      check({tag, "_ready_cycle"}, n, 3);
      check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      @(negedge clk);
      check({tag, "_idle"}, {29'd0, mif0.mem_ready, mif0.busy, mif0.access_err}, 32'd0);
   endtask

   initial begin
      int   n1, n4, c1, c4;
      logic e1, e4;

      do_reset();
      check("reset_ctl", {29'd0, mif0.mem_ready, mif0.busy, mif0.access_err}, 32'd0);
      check("reset_ir", mif0.ir_out, 32'h0);
      check("reset_mdr", mif0.mdr_out, 32'h0);

      // Seed the array through the write path; contents survive reset.
      req("seed0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h00500093, 1'b0);
      req("seed40", 1'b0, 1'b1, 1'b0, 32'h40, 32'h0CAFE000, 1'b0);
      do_reset();

      req("rd_ir", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      check("rd_ir_ir", mif0.ir_out, 32'h00500093);
      check("rd_ir_mdr", mif0.mdr_out, 32'h0);

      req("wr10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      check("wr10_mdr", mif0.mdr_out, 32'h0);
      req("rd10", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
      check("rd10_mdr", mif0.mdr_out, 32'hDEADBEEF);
      check("rd10_ir", mif0.ir_out, 32'h00500093);

      req("both20", 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0);
      check("both20_mdr", mif0.mdr_out, 32'hDEADBEEF);
      req("rd20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
      check("rd20_mdr", mif0.mdr_out, 32'h12345678);

      req("mis6", 1'b1, 1'b0, 1'b1, 32'h6, 32'h0, 1'b1);
      check("mis6_ir", mif0.ir_out, 32'h00500093);
      check("mis6_mdr", mif0.mdr_out, 32'h12345678);

      req("oor_ir", 1'b1, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h0, 1'b0);
      check("oor_ir_ir", mif0.ir_out, 32'h0);

      // Reset lands one cycle after acceptance, before the commit edge.
      @(negedge clk);
      wr = 1'b1; a = 32'h40; d = 32'hAAAA5555;
      @(negedge clk);
      check("abort_busy", {31'd0, mif0.busy}, 32'd1);
      reset = 1'b1; wr = 1'b0;
      @(negedge clk);
      check("abort_ctl", {29'd0, mif0.mem_ready, mif0.busy, mif0.access_err}, 32'd0);
      check("abort_ir", mif0.ir_out, 32'h0);
      check("abort_mdr", mif0.mdr_out, 32'h0);
      reset = 1'b0;
      req("rd40", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
      check("rd40_mdr", mif0.mdr_out, 32'h0CAFE000);

      // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
      do_reset();
      sweep_en = 1'b1;
      @(negedge clk);
      wr = 1'b1; a = 32'h8; d = 32'h5A5A5A5A;
      @(negedge clk);
      wr = 1'b0;
      repeat (8) @(negedge clk);
      rd = 1'b1; irw = 1'b0;
      @(negedge clk);
      rd = 1'b0;
      repeat (8) @(negedge clk);
      check("sw_pre_mdr1", mif1.mdr_out, 32'h5A5A5A5A);
      check("sw_pre_mdr4", mif4.mdr_out, 32'h5A5A5A5A);

      n1 = 0; n4 = 0; c1 = 0; c4 = 0; e1 = 1'b0; e4 = 1'b0;
      rd = 1'b1; irw = 1'b0; a = 32'(4 * DEPTH);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mif1.mem_ready) begin
            c1++;
            if (n1 == 0) n1 = k;
            e1 |= mif1.access_err;
         end
         if (mif4.mem_ready) begin
            c4++;
            if (n4 == 0) n4 = k;
            e4 |= mif4.access_err;
         end
         if (k == 1) begin
            rd = 1'b0; wr = 1'b1; a = 32'hC; d = 32'hFFFF0000;
         end
         if (k == 2) wr = 1'b0;
      end
      check("sw_l1_cycle", n1, 2);
      check("sw_l1_count", c1, 1);
      check("sw_l1_mdr", mif1.mdr_out, 32'h0);
      check("sw_l1_err", {31'd0, e1}, 32'd0);
      check("sw_l4_cycle", n4, 5);
      check("sw_l4_count", c4, 1);
      check("sw_l4_mdr", mif4.mdr_out, 32'h0);
      check("sw_l4_err", {31'd0, e4}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_mem_ctrl.md
Name: multicycle_mem_ctrl

Overview:
Unified instruction/data memory controller for the multi-cycle RV32I core. It sits directly downstream of the control unit and consumes its mem_read, mem_write and ir_write strobes, plus the lorD-muxed address. It performs word accesses with a configurable latency and returns a ready pulse so the FSM can stall. It owns the instruction register (IR) and the memory data register (MDR).

Parameters:
MEM_DEPTH, 16384, number of 32-bit words in the backing array
LATENCY, 2, cycles spent in ACCESS per request; legal range is 1 to 15
ADDR_W, 32, byte address width

Ports:
clk  input  1  core clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  read request from the control unit
mem_write  input  1  write request from the control unit
ir_write  input  1  sampled with a read request: 1 sends the read data to IR, 0 sends it to MDR
addr  input  ADDR_W  byte address, already muxed between PC and ALUOut by lorD
wdata  input  32  store data (register B)
mem_ready  output  1  one-cycle pulse marking completion of the accepted request
busy  output  1  high from the cycle after acceptance until mem_ready
ir_out  output  32  instruction register
mdr_out  output  32  memory data register
access_err  output  1  pulses with mem_ready when the accepted request was misaligned

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, mem_ready=0, busy=0, ir_out=0, mdr_out=0, access_err=0. Memory array contents are not reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_read|mem_write is high in cycle T, the block latches addr, wdata, op and ir_write, loads cnt=LATENCY-1, and enters ACCESS.
  - If mem_write and mem_read are both high, the write wins and the read is dropped.
- ACCESS:
  - busy=1.
  - While cnt!=0: cnt decrements and the state stays ACCESS.
  - At the edge where cnt==0, the array operation commits and the state moves to DONE.
  - Write commit: the latched wdata is stored to word index addr[ADDR_W-1:2].
  - Read commit: the array word is loaded into ir_out if the latched ir_write=1, otherwise into mdr_out.
- DONE:
  - mem_ready=1 and busy=1 for exactly one cycle.
  - ir_out/mdr_out already hold the new value in this cycle.
  - The next state is IDLE.
- Latency: a request accepted in cycle T gives ACCESS in T+1..T+LATENCY and mem_ready in T+LATENCY+1. Back-to-back requests therefore occur at most every LATENCY+2 cycles.
- Requests raised during ACCESS or DONE are ignored and not queued. The control unit holds its strobes until it sees mem_ready.
- ir_out and mdr_out change only on a read commit; otherwise they hold their value.
- Misalignment (latched addr[1:0]!=0):
  - No array access takes place.
  - IR and MDR are unchanged.
  - Full latency still applies.
  - access_err=1 together with mem_ready.
- Out of range (word index >= MEM_DEPTH):
  - A read loads 32'h0 into the selected register.
  - A write is dropped.
  - access_err is not asserted.
- Reset mid-operation: an in-flight request is aborted. If reset arrives before the commit edge, no write occurs. The state returns to IDLE with all outputs at their reset values.
- Word access only; there are no byte or half-word enables. Arithmetic on cnt is 4-bit unsigned.

Test Plan:
- Reset, then read at addr=0x0 with ir_write=1, array[0]=0x00500093, LATENCY=2: request accepted at T → busy high at T+1..T+3, mem_ready at T+3, ir_out=0x00500093, mdr_out stays 0.
- Write addr=0x10 with wdata=0xDEADBEEF, then read addr=0x10 with ir_write=0 → mdr_out=0xDEADBEEF at the second mem_ready, and ir_out is unchanged.
- Read and write both high at addr=0x20 with wdata=0x12345678 → only the write commits; a later read gives mdr_out=0x12345678 and MDR is unchanged by the first request.
- Read at addr=0x6 → mem_ready and access_err pulse together at T+3, and ir_out/mdr_out hold their previous values.
- Write addr=0x40 with 0xAAAA5555, with reset asserted at T+1 (before commit) → outputs return to reset values; a later read of 0x40 returns the old contents (e.g. 0x0).
- Sweep LATENCY=1 and LATENCY=4 with reads at addr=4*(MEM_DEPTH) and a new request issued during busy → mem_ready at T+2 and T+5 respectively, mdr_out=0, and the busy-time request is ignored with no extra mem_ready.
